usb_rx: RTL and testbench
=========================

USB_RX -- requirements
Module: usb_rx

Interface
REQ-001 SHALL have ports: clk in 1, system clock, 8 clk per USB bit time.
REQ-002 SHALL have ports: n_rst in 1, reset, asynchronous, active-low.
REQ-003 SHALL have ports: dplus_in in 1, bus D+ (asynchronous to clk).
REQ-004 SHALL have ports: dminus_in in 1, bus D- (asynchronous to clk).
REQ-005 SHALL have ports: rx_packet out 3, decoded PID: 0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 STALL.
REQ-006 SHALL have ports: rx_packet_data out 8, payload byte, valid with store_rx_packet_data.
REQ-007 SHALL have ports: store_rx_packet_data out 1, one-cycle strobe per stored payload byte.
REQ-008 SHALL have ports: rx_data_ready out 1, one-cycle strobe at clean EOP of a valid packet.
REQ-009 SHALL have ports: rx_transfer_active out 1, high from first SYNC edge until return to idle.
REQ-010 SHALL have ports: rx_error out 1, level, set on any packet error, cleared at next SYNC start.

Function
REQ-011 SHALL pass dplus_in/dminus_in through 2-flop synchronizers before any use.
REQ-012 Idle (J) SHALL be D+=1/D-=0; K is D+=0/D-=1; SE0 is both 0.
REQ-013 Bit timer: 3-bit counter SHALL restart on every synchronized D+ transition, sample at count 3, and free-run (wrap 7->0) between transitions.
REQ-014 NRZI decode: sampled level equal to previous sample SHALL yield 1, change SHALL yield 0; previous level initialised to J at packet start.
REQ-015 Bit unstuffing: after six consecutive decoded 1s the next bit SHALL be discarded; if it is 1, SHALL flag stuff error.
REQ-016 Bits SHALL shift in LSB first; byte complete after 8 unstuffed bits.
REQ-017 FSM states SHALL be IDLE, SYNC, PID, TOKEN, DATA, HSHAKE, EOP, ERR_WAIT.
REQ-018 IDLE->SYNC on first J-to-K transition; rx_transfer_active rises the same cycle it is detected.
REQ-019 SYNC byte SHALL equal 8'h80 (KJKJKJKK); mismatch -> ERR_WAIT.
REQ-020 PID byte: upper nibble SHALL equal ~lower nibble and value SHALL be one of E1,69,C3,4B,D2,5A,1E; else ERR_WAIT.
REQ-021 rx_packet SHALL update one cycle after PID byte completes and hold until next SYNC start (reset to 0 at SYNC start).
REQ-022 OUT/IN -> TOKEN: exactly 2 further bytes, not stored, then SE0 required.
REQ-023 ACK/NAK/STALL -> HSHAKE: SE0 required immediately after PID.
REQ-024 DATA0/DATA1 -> DATA: bytes pass through a 2-byte delay buffer; a byte is strobed out only when a third byte arrives, so the final 2 (CRC16) are never stored.
REQ-025 DATA payload SHALL be 0-64 bytes; 65th stored byte -> ERR_WAIT without strobing it.
REQ-026 CRC content SHALL NOT be checked.
REQ-027 EOP: SE0 for 2 bit times then J; SE0 arriving mid-byte or with fewer than 2 buffered DATA bytes -> error.
REQ-028 Clean EOP SHALL pulse rx_data_ready one cycle, then IDLE; rx_transfer_active falls the same cycle.
REQ-029 Any error SHALL set rx_error, suppress rx_data_ready and further strobes, and enter ERR_WAIT until EOP followed by 1 bit time of J, then IDLE.
REQ-030 SE0 seen in IDLE SHALL be ignored.

Reset
REQ-031 On n_rst low, asynchronously: FSM IDLE, rx_packet 0, rx_packet_data 0, all strobes 0, rx_transfer_active 0, rx_error 0, synchronizers J.
REQ-032 Reset mid-packet SHALL abandon the packet with no strobes; reception resumes at next SYNC.

Verification
REQ-033 Reset: after release with bus idle -> all outputs 0, rx_packet 0.
REQ-034 ACK packet (SYNC, D2, EOP) -> rx_packet=5, rx_data_ready pulses once, no store strobes, rx_error 0.
REQ-035 DATA0 with payload 3F,FF,00 + 2 CRC bytes -> 3 strobes with 3F,FF,00 in order, rx_packet=3, one rx_data_ready.
REQ-036 Payload FF (forces stuffed 0 after six 1s) -> byte received as FF; stuffed bit replaced by 1 -> rx_error=1, no rx_data_ready.
REQ-037 PID 8'hE0 -> rx_error=1, rx_packet stays 0, following valid NAK packet clears rx_error and gives rx_packet=6.
REQ-038 n_rst asserted after 2 payload bytes of DATA1 -> outputs reset immediately, no strobes; next IN token decodes rx_packet=2.

Source files
------------

// File: rtl/usb_rx.sv
// USB full-speed receiver: recovers bits from D+/D-, strips SYNC, decodes the PID and strobes out payload bytes.
// Latency: a payload byte is strobed one cycle after the byte two positions behind it completes; rx_packet follows the PID byte by one cycle.
// Backpressure: none, the bus cannot be stalled, so downstream must take every store_rx_packet_data strobe.
module usb_rx (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dplus_in,
    input  logic       dminus_in,
    output logic [2:0] rx_packet,
    output logic [7:0] rx_packet_data,
    output logic       store_rx_packet_data,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error
);

    typedef enum logic [2:0] {IDLE, SYNC, PID, TOKEN, DATA, HSHAKE, EOP, ERR_WAIT} state_t;

    state_t      state, next_state;
    logic        dp_m, dp_s, dp_d, dm_m, dm_s;
    logic [2:0]  bit_tmr;
    logic        prev_lvl;
    logic [2:0]  ones_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  sr;
    logic [1:0]  tok_cnt;
    logic [1:0]  hold_cnt;
    logic [7:0]  hold0, hold1;
    logic [6:0]  stored;
    logic [1:0]  se0_cnt;
    logic        se0_seen;

    logic        dp_edge, bit_smp, se0, is_j, is_k, sync_start, receiving;
    logic        nrzi_bit, stuff_bit, data_bit_vld, stuff_err, byte_done;
    logic [7:0]  byte_val;
    logic [2:0]  pid_code;
    logic        err, store_en, rdy_set;

    assign dp_edge      = dp_s ^ dp_d;
    assign bit_smp      = (bit_tmr == 3'd3) && !dp_edge;
    assign se0          = !dp_s && !dm_s;
    assign is_j         = dp_s && !dm_s;
    assign is_k         = !dp_s && dm_s;
    assign sync_start   = (state == IDLE) && dp_d && is_k;
    assign receiving    = state inside {SYNC, PID, TOKEN, DATA, HSHAKE};
    assign nrzi_bit     = (dp_s == prev_lvl);
    // Six decoded 1s in a row means the next bit is a stuff bit, never data.
    assign stuff_bit    = (ones_cnt == 3'd6);
    assign data_bit_vld = bit_smp && receiving && !se0 && !stuff_bit;
    assign stuff_err    = bit_smp && receiving && !se0 && stuff_bit && nrzi_bit;
    assign byte_done    = data_bit_vld && (bit_cnt == 3'd7);
    assign byte_val     = {nrzi_bit, sr[7:1]};

    assign rx_transfer_active = (state != IDLE) || sync_start;

    always_comb begin
        pid_code = 3'd0;
        case (byte_val)
            8'hE1:   pid_code = 3'd1;
            8'h69:   pid_code = 3'd2;
            8'hC3:   pid_code = 3'd3;
            8'h4B:   pid_code = 3'd4;
            8'hD2:   pid_code = 3'd5;
            8'h5A:   pid_code = 3'd6;
            8'h1E:   pid_code = 3'd7;
            default: pid_code = 3'd0;
        endcase
        if (byte_val[7:4] != ~byte_val[3:0])
            pid_code = 3'd0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        err        = 1'b0;
        store_en   = 1'b0;
        rdy_set    = 1'b0;
        case (state)
            IDLE: begin
                if (sync_start)
                    next_state = SYNC;
            end
            SYNC: begin
                if ((bit_smp && se0) || stuff_err)
                    err = 1'b1;
                else if (byte_done) begin
                    if (byte_val != 8'h80)
                        err = 1'b1;
                    else
                        next_state = PID;
                end
            end
            PID: begin
                if ((bit_smp && se0) || stuff_err)
                    err = 1'b1;
                else if (byte_done) begin
                    case (pid_code)
                        3'd0:       err = 1'b1;
                        3'd1, 3'd2: next_state = TOKEN;
                        3'd3, 3'd4: next_state = DATA;
                        default:    next_state = HSHAKE;
                    endcase
                end
            end
            TOKEN: begin
                if (bit_smp && se0) begin
                    if (tok_cnt == 2'd2 && bit_cnt == 3'd0)
                        next_state = EOP;
                    else
                        err = 1'b1;
                end else if (stuff_err || (byte_done && tok_cnt == 2'd2))
                    err = 1'b1;
            end
            DATA: begin
                if (bit_smp && se0) begin
                    if (bit_cnt == 3'd0 && hold_cnt == 2'd2)
                        next_state = EOP;
                    else
                        err = 1'b1;
                end else if (stuff_err)
                    err = 1'b1;
                else if (byte_done && hold_cnt == 2'd2) begin
                    if (stored == 7'd64)
                        err = 1'b1;
                    else
                        store_en = 1'b1;
                end
            end
            HSHAKE: begin
                if (bit_smp) begin
                    if (se0)
                        next_state = EOP;
                    else
                        err = 1'b1;
                end
            end
            EOP: begin
                if (bit_smp && !se0) begin
                    if (is_j && se0_cnt >= 2'd2) begin
                        rdy_set    = 1'b1;
                        next_state = IDLE;
                    end else
                        err = 1'b1;
                end
            end
            ERR_WAIT: begin
                if (bit_smp && is_j && se0_seen)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (err)
            next_state = ERR_WAIT;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_m                 <= 1'b1;
            dp_s                 <= 1'b1;
            dp_d                 <= 1'b1;
            dm_m                 <= 1'b0;
            dm_s                 <= 1'b0;
            bit_tmr              <= 3'd0;
            prev_lvl             <= 1'b1;
            ones_cnt             <= 3'd0;
            bit_cnt              <= 3'd0;
            sr                   <= 8'd0;
            tok_cnt              <= 2'd0;
            hold_cnt             <= 2'd0;
            hold0                <= 8'd0;
            hold1                <= 8'd0;
            stored               <= 7'd0;
            se0_cnt              <= 2'd1;
            se0_seen             <= 1'b0;
            rx_packet            <= 3'd0;
            rx_packet_data       <= 8'd0;
            store_rx_packet_data <= 1'b0;
            rx_data_ready        <= 1'b0;
            rx_error             <= 1'b0;
        end else begin
            dp_m    <= dplus_in;
            dp_s    <= dp_m;
            dp_d    <= dp_s;
            dm_m    <= dminus_in;
            dm_s    <= dm_m;
            bit_tmr <= dp_edge ? 3'd0 : bit_tmr + 3'd1;

            if (state == IDLE) begin
                prev_lvl <= 1'b1;
                ones_cnt <= 3'd0;
                bit_cnt  <= 3'd0;
                sr       <= 8'd0;
            end else begin
                if (bit_smp && !se0)
                    prev_lvl <= dp_s;
                if (bit_smp && receiving && !se0)
                    ones_cnt <= (stuff_bit || !nrzi_bit) ? 3'd0 : ones_cnt + 3'd1;
                if (data_bit_vld) begin
                    sr      <= byte_val;
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end

            // Two-deep hold keeps the trailing CRC16 from ever being strobed.
            if (state == PID) begin
                tok_cnt  <= 2'd0;
                hold_cnt <= 2'd0;
                stored   <= 7'd0;
            end else if (byte_done) begin
                if (state == TOKEN)
                    tok_cnt <= tok_cnt + 2'd1;
                if (state == DATA) begin
                    if (hold_cnt == 2'd0) begin
                        hold0    <= byte_val;
                        hold_cnt <= 2'd1;
                    end else if (hold_cnt == 2'd1) begin
                        hold1    <= byte_val;
                        hold_cnt <= 2'd2;
                    end else begin
                        hold0 <= hold1;
                        hold1 <= byte_val;
                    end
                end
            end
            if (store_en)
                stored <= stored + 7'd1;

            if (state != EOP)
                se0_cnt <= 2'd1;
            else if (bit_smp && se0 && se0_cnt != 2'd3)
                se0_cnt <= se0_cnt + 2'd1;

            if (state != ERR_WAIT)
                se0_seen <= bit_smp && se0;
            else if (bit_smp && se0)
                se0_seen <= 1'b1;

            store_rx_packet_data <= store_en;
            if (store_en)
                rx_packet_data <= hold0;
            rx_data_ready <= rdy_set;

            if (sync_start) begin
                rx_packet <= 3'd0;
                rx_error  <= 1'b0;
            end else begin
                if (state == PID && byte_done)
                    rx_packet <= pid_code;
                if (err)
                    rx_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_rx.sv
// Directed bench for usb_rx: NRZI/bit-stuffing encoder drives the bus, a negedge monitor records strobes.
module tb_usb_rx;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       dplus_in;
    logic       dminus_in;
    logic [2:0] rx_packet;
    logic [7:0] rx_packet_data;
    logic       store_rx_packet_data;
    logic       rx_data_ready;
    logic       rx_transfer_active;
    logic       rx_error;

    usb_rx dut (
        .clk                  (tb_clk),
        .n_rst                (n_rst),
        .dplus_in             (dplus_in),
        .dminus_in            (dminus_in),
        .rx_packet            (rx_packet),
        .rx_packet_data       (rx_packet_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_data_ready        (rx_data_ready),
        .rx_transfer_active   (rx_transfer_active),
        .rx_error             (rx_error)
    );

    always #5 tb_clk = ~tb_clk;

    int         n_vec = 0;
    int         n_bad = 0;
    int         rdy_cnt = 0;
    int         act_cnt = 0;
    logic [7:0] st_q[$];
    int         b_st, b_rdy, b_act;
    logic [7:0] pkt [0:79];
    bit         tx_lvl;

    always @(negedge tb_clk) begin
        if (store_rx_packet_data)
            st_q.push_back(rx_packet_data);
        if (rx_data_ready)
            rdy_cnt++;
        if (rx_transfer_active)
            act_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_st  = st_q.size();
        b_rdy = rdy_cnt;
        b_act = act_cnt;
    endtask

    task automatic send_bit(input bit b);
        if (!b)
            tx_lvl = ~tx_lvl;
        dplus_in  = tx_lvl;
        dminus_in = ~tx_lvl;
        #80;
    endtask

    // SYNC + pkt[0..n-1]; stuffing counted from SYNC; bad_stuff makes the first stuff bit a 1.
    task automatic send_pkt(input int n, input bit do_eop, input bit bad_stuff);
        int         ones;
        bit         done_bad;
        logic [7:0] by;
        ones     = 0;
        done_bad = 1'b0;
        tx_lvl   = 1'b1;
        for (int i = -1; i < n; i++) begin
            if (i < 0)
                by = 8'h80;
            else
                by = pkt[i];
            for (int k = 0; k < 8; k++) begin
                send_bit(by[k]);
                ones = by[k] ? ones + 1 : 0;
                if (ones == 6) begin
                    send_bit(bad_stuff && !done_bad);
                    done_bad = done_bad | bad_stuff;
                    ones = 0;
                end
            end
        end
        if (do_eop) begin
            dplus_in  = 1'b0;
            dminus_in = 1'b0;
            #160;
            dplus_in  = 1'b1;
            dminus_in = 1'b0;
            #320;
        end
    endtask

    initial begin
        int nmis;
        n_rst     = 1'b0;
        dplus_in  = 1'b1;
        dminus_in = 1'b0;
        #42 n_rst = 1'b1;
        #200;

        chk("rst_packet", rx_packet, 0);
        chk("rst_data", rx_packet_data, 0);
        chk("rst_store", store_rx_packet_data, 0);
        chk("rst_ready", rx_data_ready, 0);
        chk("rst_active", rx_transfer_active, 0);
        chk("rst_error", rx_error, 0);

        // SE0 on an idle bus
        mark();
        dplus_in = 1'b0; dminus_in = 1'b0; #160;
        dplus_in = 1'b1; #320;
        chk("idle_se0_active", act_cnt - b_act, 0);
        chk("idle_se0_error", rx_error, 0);

        // ACK
        mark();
        pkt[0] = 8'hD2;
        send_pkt(1, 1, 0);
        chk("ack_pid", rx_packet, 5);
        chk("ack_ready", rdy_cnt - b_rdy, 1);
        chk("ack_stores", st_q.size() - b_st, 0);
        chk("ack_error", rx_error, 0);
        chk("ack_active_seen", int'(act_cnt != b_act), 1);
        chk("ack_active_end", rx_transfer_active, 0);

        // DATA0 3F FF 00 + CRC
        mark();
        pkt[0] = 8'hC3; pkt[1] = 8'h3F; pkt[2] = 8'hFF; pkt[3] = 8'h00; pkt[4] = 8'h12; pkt[5] = 8'h34;
        send_pkt(6, 1, 0);
        chk("d0_stores", st_q.size() - b_st, 3);
        if (st_q.size() - b_st == 3) begin
            chk("d0_byte0", st_q[b_st], 8'h3F);
            chk("d0_byte1", st_q[b_st+1], 8'hFF);
            chk("d0_byte2", st_q[b_st+2], 8'h00);
        end
        chk("d0_pid", rx_packet, 3);
        chk("d0_ready", rdy_cnt - b_rdy, 1);
        chk("d0_error", rx_error, 0);

        // FF payload with a proper stuff bit
        mark();
        pkt[0] = 8'hC3; pkt[1] = 8'hFF; pkt[2] = 8'h12; pkt[3] = 8'h34;
        send_pkt(4, 1, 0);
        chk("ff_stores", st_q.size() - b_st, 1);
        if (st_q.size() - b_st == 1)
            chk("ff_byte", st_q[b_st], 8'hFF);
        chk("ff_ready", rdy_cnt - b_rdy, 1);
        chk("ff_error", rx_error, 0);

        // same packet, stuff bit replaced by a 1
        mark();
        send_pkt(4, 1, 1);
        chk("stufferr_error", rx_error, 1);
        chk("stufferr_ready", rdy_cnt - b_rdy, 0);
        chk("stufferr_stores", st_q.size() - b_st, 0);

        // bad PID, then NAK
        mark();
        pkt[0] = 8'hE0;
        send_pkt(1, 1, 0);
        chk("badpid_error", rx_error, 1);
        chk("badpid_packet", rx_packet, 0);
        chk("badpid_ready", rdy_cnt - b_rdy, 0);
        mark();
        pkt[0] = 8'h5A;
        send_pkt(1, 1, 0);
        chk("nak_error", rx_error, 0);
        chk("nak_pid", rx_packet, 6);
        chk("nak_ready", rdy_cnt - b_rdy, 1);

        // DATA0 ending with only one buffered byte
        mark();
        pkt[0] = 8'hC3; pkt[1] = 8'h12;
        send_pkt(2, 1, 0);
        chk("short_error", rx_error, 1);
        chk("short_ready", rdy_cnt - b_rdy, 0);

        // OUT token with a third byte
        mark();
        pkt[0] = 8'hE1; pkt[1] = 8'h00; pkt[2] = 8'h10; pkt[3] = 8'h55;
        send_pkt(4, 1, 0);
        chk("tok3_error", rx_error, 1);
        chk("tok3_ready", rdy_cnt - b_rdy, 0);
        chk("tok3_pid", rx_packet, 1);

        // 64-byte payload: the maximum
        mark();
        pkt[0] = 8'hC3;
        for (int i = 0; i < 64; i++)
            pkt[i+1] = 8'(i);
        pkt[65] = 8'h12; pkt[66] = 8'h34;
        send_pkt(67, 1, 0);
        chk("max_stores", st_q.size() - b_st, 64);
        nmis = 0;
        if (st_q.size() - b_st == 64)
            for (int i = 0; i < 64; i++)
                if (st_q[b_st+i] != 8'(i))
                    nmis++;
        chk("max_bytes_wrong", nmis, 0);
        chk("max_ready", rdy_cnt - b_rdy, 1);
        chk("max_error", rx_error, 0);

        // 65-byte payload: one too many
        mark();
        for (int i = 0; i < 65; i++)
            pkt[i+1] = 8'(i);
        pkt[66] = 8'h12; pkt[67] = 8'h34;
        send_pkt(68, 1, 0);
        chk("over_stores", st_q.size() - b_st, 64);
        chk("over_error", rx_error, 1);
        chk("over_ready", rdy_cnt - b_rdy, 0);

        // reset in the middle of a DATA1 packet
        mark();
        pkt[0] = 8'h4B; pkt[1] = 8'h11; pkt[2] = 8'h22;
        send_pkt(3, 0, 0);
        n_rst = 1'b0;
        #1;
        chk("midrst_active", rx_transfer_active, 0);
        chk("midrst_error", rx_error, 0);
        chk("midrst_packet", rx_packet, 0);
        chk("midrst_data", rx_packet_data, 0);
        chk("midrst_store", store_rx_packet_data, 0);
        chk("midrst_ready", rx_data_ready, 0);
        dplus_in  = 1'b1;
        dminus_in = 1'b0;
        #199;
        n_rst = 1'b1;
        #200;
        chk("midrst_stores", st_q.size() - b_st, 0);

        // IN token after the reset
        mark();
        pkt[0] = 8'h69; pkt[1] = 8'h00; pkt[2] = 8'h10;
        send_pkt(3, 1, 0);
        chk("in_pid", rx_packet, 2);
        chk("in_ready", rdy_cnt - b_rdy, 1);
        chk("in_error", rx_error, 0);
        chk("in_stores", st_q.size() - b_st, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
